// File: rtl/clock_div_multi_if.sv
// Control/status bundle for the multi-channel clock-enable generator.
// The slave modport is the divider block; the master side drives enables and divisor loads.
interface clock_div_multi_if #(
  parameter int unsigned CH  = 4,
  parameter int unsigned W   = 25,
  parameter int unsigned CHW = 2
);
  logic [CH-1:0]  en;
  logic           load;
  logic [CHW-1:0] load_ch;
  logic [W-1:0]   load_div;
  logic [CH-1:0]  tick;
  logic [CH-1:0]  sq;

  modport master (
    output en,
    output load,
    output load_ch,
    output load_div,
    input  tick,
    input  sq
  );

  modport slave (
    input  en,
    input  load,
    input  load_ch,
    input  load_div,
    output tick,
    output sq
  );
endinterface

// File: rtl/clock_div_multi.sv
// Multi-channel programmable clock-enable generator.
// Each channel divides the master clock (or, when cascaded, the previous channel's terminal
// count) by a run-time loadable divisor and emits a one-cycle tick plus a near-50% square wave.
module clock_div_multi #(
  parameter int unsigned CH      = 4,
  parameter int unsigned W       = 25,
  parameter int unsigned CHW     = 2,
  parameter int unsigned DEF_DIV = 25175000,
  parameter int unsigned CASCADE = 0
) (
  input  logic              i_mclk,
  input  logic              i_nrst,
  clock_div_multi_if.slave  bus
);

  logic [W-1:0]  r_div [CH];
  logic [W-1:0]  r_cnt [CH];
  logic [CH-1:0] r_tick;
  logic [CH-1:0] r_sq;

  logic [W-1:0]  w_d       [CH];
  logic [W-1:0]  w_h       [CH];
  logic [W-1:0]  w_cnt_nxt [CH];
  logic [CH-1:0] w_adv;
  logic [CH-1:0] w_tc;
  logic [CH-1:0] w_load_hit;

  // Per-channel effective divisor, advance qualifier and terminal count. The carry walks the
  // chain in channel order so a cascaded tick propagates through every stage in one cycle.
  always_comb begin
    logic v_carry;
    v_carry = 1'b1;
    for (int i = 0; i < CH; i++) begin
      w_d[i]        = (r_div[i] == '0) ? W'(1) : r_div[i];
      w_h[i]        = w_d[i] >> 1;
      w_cnt_nxt[i]  = (r_cnt[i] == w_d[i] - W'(1)) ? '0 : r_cnt[i] + W'(1);
      // Out-of-range load_ch never matches any channel, so such a load is a no-op.
      w_load_hit[i] = bus.load && (int'(bus.load_ch) == i);
      w_adv[i]      = bus.en[i] & ((CASCADE != 0) ? v_carry : 1'b1);
      // A load on this channel masks its terminal count, including toward the next stage.
      w_tc[i]       = w_adv[i] & (r_cnt[i] == w_d[i] - W'(1)) & ~w_load_hit[i];
      v_carry       = w_tc[i];
    end
  end

  // Divisor/counter state and registered tick/square outputs; a load overrides counting.
  always_ff @(posedge i_mclk or negedge i_nrst) begin
    if (!i_nrst) begin
      for (int i = 0; i < CH; i++) begin
        r_div[i] <= W'(DEF_DIV);
        r_cnt[i] <= '0;
      end
      r_tick <= '0;
      r_sq   <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (w_load_hit[i]) begin
          r_div[i]  <= bus.load_div;
          r_cnt[i]  <= '0;
          r_tick[i] <= 1'b0;
          r_sq[i]   <= 1'b0;
        end else if (w_adv[i]) begin
          r_cnt[i]  <= w_cnt_nxt[i];
          r_sq[i]   <= (w_cnt_nxt[i] < w_h[i]);
          r_tick[i] <= w_tc[i];
        end else begin
          r_tick[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.tick = r_tick;
  assign bus.sq   = r_sq;

endmodule

// File: tb/tb_clock_div_multi.sv
// Directed bench: independent channels (dut_a, 3 channels so load_ch=3 is out of range)
// and a cascaded pair (dut_b).
module tb_clock_div_multi;

  logic clk;
  logic nrst;
  int   total;
  int   bad;

  clock_div_multi_if #(.CH(3), .W(25), .CHW(2)) bus_a ();
  clock_div_multi_if #(.CH(2), .W(25), .CHW(1)) bus_b ();

  clock_div_multi #(
    .CH(3), .W(25), .CHW(2), .DEF_DIV(4), .CASCADE(0)
  ) u_dut_a (
    .i_mclk (clk),
    .i_nrst (nrst),
    .bus    (bus_a)
  );

  clock_div_multi #(
    .CH(2), .W(25), .CHW(1), .DEF_DIV(4), .CASCADE(1)
  ) u_dut_b (
    .i_mclk (clk),
    .i_nrst (nrst),
    .bus    (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Bit k of tp/sp is the expected channel-0 tick/sq after the (k+1)-th edge.
  task automatic run_a(input string tag, input int n, input logic [15:0] tp,
                       input logic [15:0] sp);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("%s tick e%0d", tag, k + 1), bus_a.tick[0], tp[k]);
      chk($sformatf("%s sq e%0d", tag, k + 1), bus_a.sq[0], sp[k]);
    end
  endtask

  task automatic load_a(input string tag, input logic [1:0] ch, input logic [24:0] div);
    bus_a.load     = 1'b1;
    bus_a.load_ch  = ch;
    bus_a.load_div = div;
    @(posedge clk);
    #1;
    bus_a.load = 1'b0;
    chk($sformatf("%s tick", tag), bus_a.tick[0], 1'b0);
    chk($sformatf("%s sq", tag), bus_a.sq[0], 1'b0);
  endtask

  task automatic load_b(input logic ch, input logic [24:0] div);
    bus_b.load     = 1'b1;
    bus_b.load_ch  = ch;
    bus_b.load_div = div;
    @(posedge clk);
    #1;
    bus_b.load = 1'b0;
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    nrst           = 1'b0;
    bus_a.en       = 3'b001;
    bus_a.load     = 1'b0;
    bus_a.load_ch  = '0;
    bus_a.load_div = '0;
    bus_b.en       = 2'b00;
    bus_b.load     = 1'b0;
    bus_b.load_ch  = '0;
    bus_b.load_div = '0;

    // Reset state
    #12;
    chk("rst tick_a", bus_a.tick[0], 1'b0);
    chk("rst sq_a", bus_a.sq[0], 1'b0);
    chk("rst tick_b", bus_b.tick[1], 1'b0);
    nrst = 1'b1;

    // Default D=4: tick on edges 4,8; sq 1,0,0,1,1,0,0,1
    run_a("def4", 8, 16'b1000_1000, 16'b1001_1001);

    // Async reset while tick=1, sq=1
    nrst = 1'b0;
    #1;
    chk("async rst tick", bus_a.tick[0], 1'b0);
    chk("async rst sq", bus_a.sq[0], 1'b0);
    #2;
    nrst = 1'b1;
    run_a("def4 again", 8, 16'b1000_1000, 16'b1001_1001);

    // D=5: tick edges 5,10; sq high on edges 1,5,6,10
    load_a("ld5", 2'd0, 25'd5);
    run_a("d5", 10, 16'b10_0001_0000, 16'b10_0011_0001);

    // D=0 and D=1: tick constantly high, sq constantly low
    load_a("ld0", 2'd0, 25'd0);
    run_a("d0", 4, 16'b1111, 16'b0000);
    load_a("ld1", 2'd0, 25'd1);
    run_a("d1", 4, 16'b1111, 16'b0000);

    // D=2: tick every second edge, sq toggles every edge
    load_a("ld2", 2'd0, 25'd2);
    run_a("d2", 4, 16'b1010, 16'b1010);

    // D=6: freeze at c=3 for 10 edges, next tick 3 advances after resuming
    load_a("ld6", 2'd0, 25'd6);
    run_a("d6 pre", 3, 16'b000, 16'b011);
    bus_a.en = 3'b000;
    run_a("d6 frozen", 10, 16'd0, 16'd0);
    bus_a.en = 3'b001;
    run_a("d6 resume", 3, 16'b100, 16'b100);

    // Load on the terminal-count cycle: no tick, restart with D=3
    load_a("ld4", 2'd0, 25'd4);
    run_a("d4 pre", 3, 16'b000, 16'b001);
    load_a("ld3 at tc", 2'd0, 25'd3);
    run_a("d3", 3, 16'b100, 16'b100);

    // Out-of-range load_ch behaves as an ordinary advancing edge with D=3
    load_a("ld oor", 2'd3, 25'd7);
    run_a("oor after", 2, 16'b10, 16'b10);
    chk("oor ch1 tick", bus_a.tick[1], 1'b0);
    chk("oor ch2 sq", bus_a.sq[2], 1'b0);

    // Cascade: D0=3, D1=4 -> tick1 every 12 edges, coincident with every 4th tick0
    load_b(1'b0, 25'd3);
    load_b(1'b1, 25'd4);
    chk("casc load tick1", bus_b.tick[1], 1'b0);
    bus_b.en = 2'b11;
    for (int k = 1; k <= 30; k++) begin
      int m;
      m = k / 3;
      @(posedge clk);
      #1;
      chk($sformatf("casc tick0 e%0d", k), bus_b.tick[0], (k % 3) == 0);
      chk($sformatf("casc tick1 e%0d", k), bus_b.tick[1], (k % 12) == 0);
      chk($sformatf("casc sq1 e%0d", k), bus_b.sq[1], (m != 0) && ((m % 4) < 2));
    end

    // Channel 0 disabled: channel 1 must freeze as well
    bus_b.en = 2'b10;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("casc frz tick0 e%0d", k), bus_b.tick[0], 1'b0);
      chk($sformatf("casc frz tick1 e%0d", k), bus_b.tick[1], 1'b0);
    end
    bus_b.en = 2'b11;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("casc res tick0 e%0d", k), bus_b.tick[0], (k % 3) == 0);
      chk($sformatf("casc res tick1 e%0d", k), bus_b.tick[1], k == 6);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
